// File: rtl/i3c_target_rx.sv
// I3C SDR target write-path receiver: oversampled START/Sr/STOP detection, address
// header match with open-drain ACK, and byte deserialisation with odd-parity T-bit check.
module i3c_target_rx #(
    parameter logic [6:0] STATIC_ADDR  = 7'h2A,
    parameter bit         BROADCAST_EN = 1'b1,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       busy_o,
    output logic       addr_match_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       start_o,
    output logic       stop_o
);

    // A single-flop synchroniser is never acceptable, so clamp the depth.
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [6:0] BCAST_ADDR = 7'h7E;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK    = 3'd2,
        DATA   = 3'd3,
        TBIT   = 3'd4,
        IGNORE = 3'd5
    } state_t;

    state_t      state_q;
    logic [SS-1:0] scl_sync;
    logic [SS-1:0] sda_sync;
    logic        scl_q;
    logic        sda_q;
    logic        scl_s;
    logic        sda_s;
    logic        scl_rise;
    logic        scl_fall;
    logic        start_det;
    logic        stop_det;
    logic [7:0]  shift_q;
    logic [3:0]  bit_cnt;
    logic        hdr_ok_q;
    logic        hdr_match;

    // Synchronisers preset to 1 so a released (idle-high) bus never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SS-2:0], scl_i};
            sda_sync <= {sda_sync[SS-2:0], sda_i};
            scl_q    <= scl_sync[SS-1];
            sda_q    <= sda_sync[SS-1];
        end
    end

    assign scl_s     = scl_sync[SS-1];
    assign sda_s     = sda_sync[SS-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    // SCL must be stable high in both samples, so an SDA edge coincident with an SCL edge is excluded.
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    // Evaluated on the 8th header rise: shift_q[6:0] holds A6..A0, sda_s is RnW.
    assign hdr_match = ((shift_q[6:0] == STATIC_ADDR) ||
                        (BROADCAST_EN && (shift_q[6:0] == BCAST_ADDR))) && !sda_s;

    // rx_valid_o is a one-cycle strobe with no back-pressure: rx_data_o is meaningful
    // in that cycle and holds its value afterwards; parity_err_o only ever pulses with it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            sda_o        <= 1'b1;
            busy_o       <= 1'b0;
            addr_match_o <= 1'b0;
            rx_data_o    <= 8'h00;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            start_o      <= 1'b0;
            stop_o       <= 1'b0;
            shift_q      <= 8'h00;
            bit_cnt      <= 4'd0;
            hdr_ok_q     <= 1'b0;
        end else begin
            start_o      <= 1'b0;
            stop_o       <= 1'b0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            if (stop_det) begin
                state_q      <= IDLE;
                stop_o       <= 1'b1;
                busy_o       <= 1'b0;
                addr_match_o <= 1'b0;
                sda_o        <= 1'b1;
                bit_cnt      <= 4'd0;
            end else if (start_det) begin
                state_q      <= ADDR;
                start_o      <= 1'b1;
                busy_o       <= 1'b1;
                addr_match_o <= 1'b0;
                sda_o        <= 1'b1;
                bit_cnt      <= 4'd0;
                hdr_ok_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        sda_o <= 1'b1;
                    end
                    ADDR: begin
                        if (scl_rise && (bit_cnt != 4'd8)) begin
                            shift_q <= {shift_q[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                hdr_ok_q <= hdr_match;
                            end
                        end else if (scl_fall && (bit_cnt == 4'd8)) begin
                            if (hdr_ok_q) begin
                                state_q      <= ACK;
                                sda_o        <= 1'b0;
                                addr_match_o <= 1'b1;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    ACK: begin
                        // Hold SDA low through the 9th clock; release on its falling edge.
                        if (scl_fall) begin
                            sda_o   <= 1'b1;
                            state_q <= DATA;
                            bit_cnt <= 4'd0;
                        end
                    end
                    DATA: begin
                        sda_o <= 1'b1;
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                state_q <= TBIT;
                            end
                        end
                    end
                    TBIT: begin
                        sda_o <= 1'b1;
                        if (scl_rise) begin
                            rx_data_o    <= shift_q;
                            rx_valid_o   <= 1'b1;
                            parity_err_o <= ~(^shift_q ^ sda_s);
                            state_q      <= DATA;
                            bit_cnt      <= 4'd0;
                        end
                    end
                    IGNORE: begin
                        sda_o <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        sda_o   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i3c_target_rx.md
Name: i3c_target_rx

Overview:
SDR write-path receiver for the target (responder) end of the I3C bus driven by our bus controller.
- Oversamples scl_i/sda_i on clk_i.
- Detects START, repeated START (Sr) and STOP.
- Matches the 7-bit address header and ACKs it in open-drain.
- Deserialises data bytes, each followed by an odd-parity T-bit, and presents bytes to the target register file with a one-cycle valid strobe.
- Reads (RnW=1) are NACKed; the read path is a separate block.

Parameters:
STATIC_ADDR, 7'h2A, target static address to match.
BROADCAST_EN, 1, when 1 the broadcast address 7'h7E with RnW=0 is also ACKed.
SYNC_STAGES, 2, flops in each scl_i/sda_i synchroniser (minimum 2).

Ports:
clk_i  input  1  system clock, at least 20x the SCL rate.
rst_ni  input  1  reset: synchronous, active-low.
scl_i  input  1  bus SCL, asynchronous.
sda_i  input  1  bus SDA, asynchronous.
sda_o  output  1  open-drain SDA drive; 0 = pull low, 1 = release.
busy_o  output  1  high from START until STOP.
addr_match_o  output  1  high from the ACKed header until the next START/Sr/STOP.
rx_data_o  output  8  last received data byte, MSB first on the bus.
rx_valid_o  output  1  one-cycle strobe; rx_data_o is valid.
parity_err_o  output  1  one-cycle strobe coincident with rx_valid_o when the T-bit fails.
start_o  output  1  one-cycle strobe on START or Sr.
stop_o  output  1  one-cycle strobe on STOP.

Behaviour:
- Reset values (rst_ni low at a clk_i edge):
  - sda_o=1, rx_data_o=0.
  - All strobes, busy_o and addr_match_o = 0.
  - FSM in IDLE; synchronisers preset to 1.
- Signal conditioning:
  - scl_s/sda_s are the synchroniser outputs; _q denotes the previous-cycle value.
  - SCL rise = scl_s & ~scl_q. SCL fall = ~scl_s & scl_q.
  - START = scl_s & scl_q & sda_q & ~sda_s.
  - STOP = scl_s & scl_q & ~sda_q & sda_s.
  - If an SDA edge coincides with an SCL edge in the same cycle, it is not START/STOP.
  - Detection latency is SYNC_STAGES+1 cycles from the pin.
- FSM states: IDLE, ADDR, ACK, DATA, TBIT, IGNORE.
- IDLE -> ADDR on START: start_o=1, busy_o=1, bit counter=0.
- ADDR:
  - Shift sda_s on each SCL rise, 8 bits (A6..A0, RnW).
  - On the 8th rise, compute match = (addr==STATIC_ADDR | (BROADCAST_EN & addr==7'h7E)) & ~RnW.
  - On the next SCL fall, go to ACK if match, otherwise to IGNORE.
- ACK:
  - sda_o=0 from entry; addr_match_o=1.
  - On the 9th SCL fall, set sda_o=1 and go to DATA with bit counter=0.
- DATA:
  - Shift on SCL rise. After the 8th rise, go to TBIT.
  - sda_o stays 1; the controller drives push-pull.
- TBIT:
  - On the 9th SCL rise, sample T.
  - Same cycle: rx_data_o<=byte, rx_valid_o=1.
  - parity_err_o = ~(^byte ^ T), i.e. odd parity required.
  - Go to DATA. The byte is delivered even when a parity error is flagged.
- IGNORE: sda_o=1; ignore SCL until START/Sr/STOP.
- START in any non-IDLE state (Sr):
  - start_o=1; addr_match_o=0; sda_o=1; go to ADDR with counter cleared.
  - A partial byte is discarded with no rx_valid_o.
- STOP in any state:
  - stop_o=1; busy_o=0; addr_match_o=0; sda_o=1; go to IDLE.
  - A partial byte is discarded.
- START/STOP take priority over SCL-edge processing in the same cycle.
- sda_o is never 0 outside ACK.
- Reset mid-transfer: return to reset values on the next clk_i edge; the bus is released immediately.

Test Plan:
- START, header 0x2A+W (0x54), byte 0xA5 with T=1 -> sda_o=0 for the 9th header clock; rx_valid_o once with rx_data_o=0xA5; parity_err_o=0.
- Same transfer but byte 0xA5 with T=0 -> rx_valid_o with rx_data_o=0xA5 and parity_err_o=1 in the same cycle.
- Header 0x2B+W -> sda_o stays 1 (NACK); following bytes produce no rx_valid_o; STOP -> stop_o=1, busy_o=0.
- Header 0x2A+R (0x55) -> NACK, IGNORE. Header 0x7E+W -> ACK with BROADCAST_EN=1; NACK with BROADCAST_EN=0.
- Sr after 4 data bits of byte 2, then header 0x54 and byte 0x3C (T=1) -> start_o pulses twice in total; the partial byte is dropped; rx_data_o=0x3C.
- rst_ni low during the ACK phase -> sda_o=1 at the next clk_i edge; all outputs return to reset values; the next START is accepted normally.
